pdp8_memseq: RTL and testbench

PDP8_MEMSEQ -- requirements
Module: pdp8_memseq

---
 rtl/pdp8_memseq.sv | 136 +++++++++++++
 tb/tb_pdp8_memseq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pdp8_memseq.sv
// PDP-8 core-memory cycle sequencer: read, write and read-pause-write cycles against an SRAM port.
// Optional read-pause-write support is built when PDP8_MEMSEQ_RMW_EN is defined.
module pdp8_memseq #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        rmw,
  input  logic [14:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  input  logic [11:0] mod_data,
  input  logic        mod_valid,
  output logic        busy,
  output logic        done,
  output logic [11:0] rdata,
  output logic        pause,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_data_in,
  input  logic [11:0] ram_data_out,
  output logic        ram_rd,
  output logic        ram_wr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_PAUSE  = 3'd2;
  localparam logic [2:0] S_WSETUP = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_WHOLD  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [14:0] r_addr;
  logic [11:0] r_wdata;
  logic [11:0] r_rdata;
  logic        w_cnt_zero;
  logic        w_rmw_cycle;

  assign w_cnt_zero = (r_cnt == 4'd0);

`ifdef PDP8_MEMSEQ_RMW_EN
  logic r_rmw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rmw <= 1'b0;
    end else if (r_state == S_IDLE && req) begin
      // A write request with rmw set is an ordinary write, so the flag only sticks for reads.
      r_rmw <= rmw & ~we;
    end
  end

  assign w_rmw_cycle = r_rmw;
  assign pause       = (r_state == S_PAUSE);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = &{1'b0, rmw, mod_valid, mod_data, (r_state == S_PAUSE)};
  assign w_rmw_cycle  = 1'b0;
  assign pause        = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 15'd0;
      r_wdata <= 12'd0;
      r_rdata <= 12'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (we) begin
              r_state <= S_WSETUP;
            end else begin
              r_state <= S_READ;
              r_cnt   <= RD_LOAD;
            end
          end
        end
        S_READ: begin
          if (w_cnt_zero) begin
            r_rdata <= ram_data_out;
            r_state <= w_rmw_cycle ? S_PAUSE : S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef PDP8_MEMSEQ_RMW_EN
        S_PAUSE: begin
          if (mod_valid) begin
            r_wdata <= mod_data;
            r_state <= S_WSETUP;
          end
        end
`endif
        S_WSETUP: begin
          r_state <= S_WRITE;
          r_cnt   <= WR_LOAD;
        end
        S_WRITE: begin
          if (w_cnt_zero) begin
            r_state <= S_WHOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WHOLD: r_state <= S_DONE;
        // DONE always returns to IDLE, guaranteeing one idle cycle between memory cycles.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them without a clock.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign ram_rd      = (r_state == S_READ);
  assign ram_wr      = (r_state == S_WRITE);
  assign ram_addr    = r_addr;
  assign ram_data_in = r_wdata;
  assign rdata       = r_rdata;

endmodule

// File: tb/tb_pdp8_memseq.sv
// Directed bench for pdp8_memseq (RD_WAIT=2, WR_WAIT=3); expectations follow PDP8_MEMSEQ_RMW_EN.
module tb_pdp8_memseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, rmw, mod_valid;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata, mod_data, ram_data_out;
  logic        busy, done, pause, ram_rd, ram_wr;
  logic [11:0] rdata, ram_data_in;
  logic [14:0] ram_addr;

  int n_checks = 0;
  int n_errors = 0;

  pdp8_memseq #(.RD_WAIT(2), .WR_WAIT(3)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .rmw(rmw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .mod_data(mod_data), .mod_valid(mod_valid),
    .busy(busy), .done(done), .rdata(rdata), .pause(pause),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_rd(ram_rd), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Control bundle: {busy, done, pause, ram_rd, ram_wr}
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_READ  = 5'b10010;
  localparam logic [4:0] C_PAUSE = 5'b10100;
  localparam logic [4:0] C_WGAP  = 5'b10000;
  localparam logic [4:0] C_WRITE = 5'b10001;
  localparam logic [4:0] C_DONE  = 5'b11000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [4:0] exp);
    check(tag, 32'({busy, done, pause, ram_rd, ram_wr}), 32'(exp));
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    ctl(tag, exp);
  endtask

  task automatic bus(input string tag, input logic [14:0] a, input logic [11:0] d);
    check({tag, "_addr"}, 32'(ram_addr), 32'(a));
    check({tag, "_wdata"}, 32'(ram_data_in), 32'(d));
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; rmw = 1'b0; mod_valid = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mod_data = '0; ram_data_out = '0;
    repeat (2) @(posedge clk);
    #1;
    ctl("reset_ctl", C_IDLE);
    bus("reset", 15'd0, 12'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    step("idle", C_IDLE);

    // Plain read of 15'o00200 returning 12'o7654.
    cpu_addr = 15'o00200; we = 1'b0; req = 1'b1; ram_data_out = 12'o7654;
    @(posedge clk); #1;
    req = 1'b0; cpu_addr = 15'o00777;
    ctl("rd_c1", C_READ);
    check("rd_c1_addr", 32'(ram_addr), 32'(15'o00200));
    step("rd_c2", C_READ);
    step("rd_c3_done", C_DONE);
    check("rd_rdata", 32'(rdata), 32'(12'o7654));
    ram_data_out = 12'o1111;
    step("rd_c4", C_IDLE);
    step("rd_c5", C_IDLE);
    check("rd_rdata_hold", 32'(rdata), 32'(12'o7654));

    // Plain write 12'o1234 to 15'o17777; inputs change after acceptance.
    cpu_addr = 15'o17777; cpu_wdata = 12'o1234; we = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; cpu_addr = 15'o00001; cpu_wdata = 12'o0000;
    ctl("wr_c1_setup", C_WGAP);
    bus("wr_c1", 15'o17777, 12'o1234);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("wr_c%0d", i + 2), C_WRITE);
      bus($sformatf("wr_c%0d", i + 2), 15'o17777, 12'o1234);
    end
    step("wr_c5_hold", C_WGAP);
    bus("wr_c5", 15'o17777, 12'o1234);
    step("wr_c6_done", C_DONE);
    check("wr_rdata_untouched", 32'(rdata), 32'(12'o7654));
    step("wr_c7", C_IDLE);

    // Read-pause-write of 15'o00010: memory returns 12'o0005, write-back 12'o0006.
    cpu_addr = 15'o00010; we = 1'b0; rmw = 1'b1; req = 1'b1;
    ram_data_out = 12'o0005; mod_data = 12'o0006; mod_valid = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; rmw = 1'b0;
    ctl("rmw_c1", C_READ);
    step("rmw_c2", C_READ);
`ifdef PDP8_MEMSEQ_RMW_EN
    for (int i = 0; i < 4; i++) step($sformatf("rmw_pause%0d", i), C_PAUSE);
    check("rmw_rdata", 32'(rdata), 32'(12'o0005));
    check("rmw_pause_addr", 32'(ram_addr), 32'(15'o00010));
    mod_valid = 1'b1;
    step("rmw_wsetup", C_WGAP);
    mod_valid = 1'b0;
    bus("rmw_wsetup", 15'o00010, 12'o0006);
    for (int i = 0; i < 3; i++) step($sformatf("rmw_write%0d", i), C_WRITE);
    bus("rmw_write", 15'o00010, 12'o0006);
    step("rmw_whold", C_WGAP);
    step("rmw_done", C_DONE);
    step("rmw_after", C_IDLE);
`else
    step("rmw_done_plain", C_DONE);
    check("rmw_rdata", 32'(rdata), 32'(12'o0005));
    mod_valid = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("rmw_no_pause%0d", i), C_IDLE);
    mod_valid = 1'b0;
    step("rmw_after", C_IDLE);
`endif

    // Write with rmw set behaves as a plain write.
    cpu_addr = 15'o00042; cpu_wdata = 12'o0777; we = 1'b1; rmw = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; rmw = 1'b0;
    ctl("wrmw_setup", C_WGAP);
    for (int i = 0; i < 3; i++) step($sformatf("wrmw_write%0d", i), C_WRITE);
    step("wrmw_hold", C_WGAP);
    step("wrmw_done", C_DONE);
    step("wrmw_idle", C_IDLE);

    // Reset in the second WRITE cycle drops ram_wr without a clock edge.
    cpu_addr = 15'o12345; cpu_wdata = 12'o4321; we = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    ctl("rst_wsetup", C_WGAP);
    step("rst_write1", C_WRITE);
    step("rst_write2", C_WRITE);
    #2 reset = 1'b1;
    #1;
    ctl("rst_async_ctl", C_IDLE);
    bus("rst_async", 15'd0, 12'd0);
    check("rst_async_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("rst_no_resume%0d", i), C_IDLE);

    // req held high: back-to-back reads separated by exactly one IDLE cycle.
    cpu_addr = 15'o00300; we = 1'b0; req = 1'b1; ram_data_out = 12'o0123;
    @(posedge clk); #1;
    ctl("hold_c1", C_READ);
    step("hold_c2", C_READ);
    step("hold_c3", C_DONE);
    step("hold_c4_gap", C_IDLE);
    step("hold_c5", C_READ);
    step("hold_c6", C_READ);
    step("hold_c7", C_DONE);
    step("hold_c8_gap", C_IDLE);
    req = 1'b0;
    step("hold_c9", C_IDLE);
    check("hold_rdata", 32'(rdata), 32'(12'o0123));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
